mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-access stage and MEM/WB pipeline register of the 64-bit pipelined datapath. Consumes the EX/MEM register outputs and drives a request/acknowledge data-memory port. Stalls the upstream pipeline while an access is outstanding, and resolves taken branches. Registers the write-back bundle for the WB stage.

## Interface
- MAX_WAIT, 15: cycles in WAIT without DMEM_ACK before the access is declared failed (1..255).

- CLK  in  1  single clock; all state changes on posedge.
- RESET  in  1  asynchronous, active-high reset.
- ALU_VAL_IN  in  64  EX/MEM ALU result; memory address for loads and stores.
- RT_READ_IN  in  64  EX/MEM store data.
- BRANCH_IN  in  64  EX/MEM branch target.
- ZERO_IN  in  1  EX/MEM ALU zero flag.
- REG_DESTINATION_IN  in  5  EX/MEM destination register.
- REGWRITE_IN, MEM2REG_IN, MEMWRITE_IN, MEMREAD_IN, BRANCH_ZERO_IN  in  1 each  EX/MEM control bits.
- DMEM_REQ  out  1  memory request; held until DMEM_ACK.
- DMEM_WE  out  1  1 = write, 0 = read; valid while DMEM_REQ.
- DMEM_ADDR  out  64  captured address; stable while DMEM_REQ.
- DMEM_WDATA  out  64  captured store data; stable while DMEM_REQ.
- DMEM_RDATA  in  64  read data; sampled on the DMEM_ACK cycle.
- DMEM_ACK  in  1  one-cycle completion strobe from memory.
- STALL  out  1  combinational; upstream registers hold when 1.
- PCSRC  out  1  combinational branch-taken.
- BRANCH_TARGET  out  64  combinational, equal to BRANCH_IN.
- MEM_ERROR  out  1  sticky timeout flag.
- READ_DATA_OUT  out  64  MEM/WB load data.
- ALU_VAL_OUT  out  64  MEM/WB ALU result.
- REG_DESTINATION_OUT  out  5  MEM/WB destination register.
- REGWRITE_OUT, MEM2REG_OUT  out  1 each  MEM/WB control bits.

## Operation
- FSM states: IDLE, WAIT, ERROR. Reset state is IDLE.
- memop = MEMREAD_IN | MEMWRITE_IN. When both bits are set, the access is a write.
- IDLE, no memop: MEM/WB loads ALU_VAL_IN, REG_DESTINATION_IN, REGWRITE_IN and MEM2REG_IN. READ_DATA_OUT holds its value. STALL=0.
- IDLE, memop:
  - STALL=1.
  - Capture DMEM_ADDR=ALU_VAL_IN, DMEM_WDATA=RT_READ_IN, DMEM_WE=MEMWRITE_IN.
  - Go to WAIT with DMEM_REQ=1 and the wait counter cleared.
  - MEM/WB loads a bubble: REGWRITE_OUT=0, MEM2REG_OUT=0.
- WAIT, no DMEM_ACK: STALL=1, REQ and captured fields held, counter increments. MEM/WB holds.
- WAIT, DMEM_ACK:
  - STALL=0.
  - MEM/WB loads the EX/MEM bundle. For reads, READ_DATA_OUT also loads DMEM_RDATA; for writes it holds.
  - DMEM_REQ drops on the next edge; go to IDLE.
- Timeout: WAIT with counter==MAX_WAIT-1 and no ACK goes to ERROR. DMEM_REQ drops and MEM_ERROR is set.
- ERROR: STALL=1 permanently and MEM/WB holds. Only RESET exits.
- DMEM_ACK outside WAIT is ignored.
- PCSRC = BRANCH_ZERO_IN & ZERO_IN & (state==IDLE).
- Counter width is 8 bits.

## Timing
- Non-memory instruction: one cycle through the stage; MEM/WB is valid on the edge after it is presented.
- Memory instruction: minimum 2 cycles, when ACK arrives in the first WAIT cycle. Latency is 1 + ACK delay.
- STALL is combinational from state, memop and DMEM_ACK. The instruction advances out of EX/MEM on the ACK edge.
- Reset values:
  - All registered outputs are 0: DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, MEM_ERROR, READ_DATA_OUT, ALU_VAL_OUT, REG_DESTINATION_OUT, REGWRITE_OUT, MEM2REG_OUT.
  - Counter is 0 and state is IDLE.
- Reset mid-access: DMEM_REQ drops asynchronously. A late DMEM_ACK after release is ignored.
- DMEM_ACK and RESET in the same cycle: reset wins and nothing is captured.

## Test plan
- Reset during WAIT with REQ=1 -> REQ, MEM_ERROR and all MEM/WB outputs read 0 immediately. An ACK the cycle after release leaves READ_DATA_OUT=0.
- ALU op, ALU_VAL_IN=0x1234, REGWRITE_IN=1, dest=5 -> next edge: ALU_VAL_OUT=0x1234, REG_DESTINATION_OUT=5, REGWRITE_OUT=1, STALL never asserted.
- Load from 0x40, DMEM_ACK 3 cycles after REQ with RDATA=0xDEADBEEF:
  - DMEM_ADDR=0x40 and WE=0; STALL high for 4 cycles.
  - Then READ_DATA_OUT=0xDEADBEEF and MEM2REG_OUT=1.
  - One bubble cycle with REGWRITE_OUT=0 precedes it.
- Store with RT_READ_IN=0x55, both MEMREAD and MEMWRITE set, immediate ACK -> DMEM_WE=1, WDATA=0x55, 2-cycle latency, READ_DATA_OUT unchanged.
- Load with no ACK, MAX_WAIT=4 -> ERROR after 4 WAIT cycles; REQ drops, MEM_ERROR=1, STALL stuck at 1 until RESET.
- BRANCH_ZERO_IN=1, ZERO_IN=1, BRANCH_IN=0x100 in IDLE -> PCSRC=1, BRANCH_TARGET=0x100. ZERO_IN=0 gives PCSRC=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register of the 64-bit datapath.
// Drives a req/ack data-memory port, stalls upstream while an access is open.
module mem_wb_stage #(
    parameter int MAX_WAIT = 15
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [63:0] ALU_VAL_IN,
    input  logic [63:0] RT_READ_IN,
    input  logic [63:0] BRANCH_IN,
    input  logic        ZERO_IN,
    input  logic [4:0]  REG_DESTINATION_IN,
    input  logic        REGWRITE_IN,
    input  logic        MEM2REG_IN,
    input  logic        MEMWRITE_IN,
    input  logic        MEMREAD_IN,
    input  logic        BRANCH_ZERO_IN,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [63:0] DMEM_ADDR,
    output logic [63:0] DMEM_WDATA,
    input  logic [63:0] DMEM_RDATA,
    input  logic        DMEM_ACK,
    output logic        STALL,
    output logic        PCSRC,
    output logic [63:0] BRANCH_TARGET,
    output logic        MEM_ERROR,
    output logic [63:0] READ_DATA_OUT,
    output logic [63:0] ALU_VAL_OUT,
    output logic [4:0]  REG_DESTINATION_OUT,
    output logic        REGWRITE_OUT,
    output logic        MEM2REG_OUT
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       memop;

    assign memop         = MEMREAD_IN | MEMWRITE_IN;
    assign BRANCH_TARGET = BRANCH_IN;
    assign PCSRC         = BRANCH_ZERO_IN & ZERO_IN & (state == S_IDLE);

    always_comb begin
        STALL = 1'b1;
        unique case (state)
            S_IDLE:  STALL = memop;
            S_WAIT:  STALL = ~DMEM_ACK;
            S_ERROR: STALL = 1'b1;
            default: STALL = 1'b1;
        endcase
    end

    // ACK has priority over the timeout on the last permitted WAIT cycle
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state               <= S_IDLE;
            wait_cnt            <= 8'd0;
            DMEM_REQ            <= 1'b0;
            DMEM_WE             <= 1'b0;
            DMEM_ADDR           <= 64'd0;
            DMEM_WDATA          <= 64'd0;
            MEM_ERROR           <= 1'b0;
            READ_DATA_OUT       <= 64'd0;
            ALU_VAL_OUT         <= 64'd0;
            REG_DESTINATION_OUT <= 5'd0;
            REGWRITE_OUT        <= 1'b0;
            MEM2REG_OUT         <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (memop) begin
                        state        <= S_WAIT;
                        wait_cnt     <= 8'd0;
                        DMEM_REQ     <= 1'b1;
                        DMEM_WE      <= MEMWRITE_IN;
                        DMEM_ADDR    <= ALU_VAL_IN;
                        DMEM_WDATA   <= RT_READ_IN;
                        REGWRITE_OUT <= 1'b0;
                        MEM2REG_OUT  <= 1'b0;
                    end else begin
                        ALU_VAL_OUT         <= ALU_VAL_IN;
                        REG_DESTINATION_OUT <= REG_DESTINATION_IN;
                        REGWRITE_OUT        <= REGWRITE_IN;
                        MEM2REG_OUT         <= MEM2REG_IN;
                    end
                end
                S_WAIT: begin
                    if (DMEM_ACK) begin
                        state               <= S_IDLE;
                        DMEM_REQ            <= 1'b0;
                        ALU_VAL_OUT         <= ALU_VAL_IN;
                        REG_DESTINATION_OUT <= REG_DESTINATION_IN;
                        REGWRITE_OUT        <= REGWRITE_IN;
                        MEM2REG_OUT         <= MEM2REG_IN;
                        if (!DMEM_WE) begin
                            READ_DATA_OUT <= DMEM_RDATA;
                        end
                    end else if (wait_cnt == LAST_WAIT) begin
                        state     <= S_ERROR;
                        DMEM_REQ  <= 1'b0;
                        MEM_ERROR <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_ERROR: begin
                    state <= S_ERROR;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a transaction-level reference model.
// Checks every cycle on the falling edge plus hand-computed literals.
module tb_mem_wb_stage;

    localparam int MW = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [63:0] ALU_VAL_IN = '0, RT_READ_IN = '0, BRANCH_IN = '0;
    logic        ZERO_IN = 1'b0;
    logic [4:0]  REG_DESTINATION_IN = '0;
    logic        REGWRITE_IN = 1'b0, MEM2REG_IN = 1'b0;
    logic        MEMWRITE_IN = 1'b0, MEMREAD_IN = 1'b0;
    logic        BRANCH_ZERO_IN = 1'b0;
    logic        DMEM_REQ, DMEM_WE;
    logic [63:0] DMEM_ADDR, DMEM_WDATA;
    logic [63:0] DMEM_RDATA = '0;
    logic        DMEM_ACK = 1'b0;
    logic        STALL, PCSRC, MEM_ERROR;
    logic [63:0] BRANCH_TARGET, READ_DATA_OUT, ALU_VAL_OUT;
    logic [4:0]  REG_DESTINATION_OUT;
    logic        REGWRITE_OUT, MEM2REG_OUT;

    int checks = 0;
    int errors = 0;

    mem_wb_stage #(.MAX_WAIT(MW)) dut (
        .CLK(CLK), .RESET(RESET),
        .ALU_VAL_IN(ALU_VAL_IN), .RT_READ_IN(RT_READ_IN),
        .BRANCH_IN(BRANCH_IN), .ZERO_IN(ZERO_IN),
        .REG_DESTINATION_IN(REG_DESTINATION_IN),
        .REGWRITE_IN(REGWRITE_IN), .MEM2REG_IN(MEM2REG_IN),
        .MEMWRITE_IN(MEMWRITE_IN), .MEMREAD_IN(MEMREAD_IN),
        .BRANCH_ZERO_IN(BRANCH_ZERO_IN),
        .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE),
        .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA),
        .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK),
        .STALL(STALL), .PCSRC(PCSRC), .BRANCH_TARGET(BRANCH_TARGET),
        .MEM_ERROR(MEM_ERROR), .READ_DATA_OUT(READ_DATA_OUT),
        .ALU_VAL_OUT(ALU_VAL_OUT),
        .REG_DESTINATION_OUT(REG_DESTINATION_OUT),
        .REGWRITE_OUT(REGWRITE_OUT), .MEM2REG_OUT(MEM2REG_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: an access is either absent, outstanding (with a
    // count of cycles already spent waiting), or has failed for good.
    bit          m_pending = 0;
    bit          m_failed = 0;
    int          m_waited = 0;
    bit          m_is_write = 0;
    logic [63:0] m_addr = '0, m_wdata = '0, m_rd = '0, m_alu = '0;
    logic [4:0]  m_dst = '0;
    bit          m_rw = 0, m_m2r = 0;

    task automatic retire_bundle();
        m_alu = ALU_VAL_IN;
        m_dst = REG_DESTINATION_IN;
        m_rw  = REGWRITE_IN;
        m_m2r = MEM2REG_IN;
    endtask

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_pending = 0; m_failed = 0; m_waited = 0;
            m_is_write = 0; m_addr = '0; m_wdata = '0; m_rd = '0;
            m_alu = '0; m_dst = '0; m_rw = 0; m_m2r = 0;
        end else if (m_failed) begin
            m_failed = 1;
        end else if (!m_pending) begin
            if (MEMREAD_IN || MEMWRITE_IN) begin
                m_pending  = 1;
                m_waited   = 0;
                m_is_write = MEMWRITE_IN;
                m_addr     = ALU_VAL_IN;
                m_wdata    = RT_READ_IN;
                m_rw       = 0;
                m_m2r      = 0;
            end else begin
                retire_bundle();
            end
        end else if (DMEM_ACK) begin
            m_pending = 0;
            retire_bundle();
            if (!m_is_write) m_rd = DMEM_RDATA;
        end else begin
            m_waited++;
            if (m_waited >= MW) begin
                m_pending = 0;
                m_failed  = 1;
            end
        end
    end

    always @(negedge CLK) begin
        logic exp_stall;
        if (m_failed)       exp_stall = 1'b1;
        else if (m_pending) exp_stall = !DMEM_ACK;
        else                exp_stall = MEMREAD_IN | MEMWRITE_IN;
        chk("stall", 64'(STALL), 64'(exp_stall));
        chk("pcsrc", 64'(PCSRC), 64'(BRANCH_ZERO_IN & ZERO_IN
                                     & !m_pending & !m_failed));
        chk("btarget", BRANCH_TARGET, BRANCH_IN);
        chk("req", 64'(DMEM_REQ), 64'(m_pending));
        chk("mem_error", 64'(MEM_ERROR), 64'(m_failed));
        chk("read_data", READ_DATA_OUT, m_rd);
        chk("alu_out", ALU_VAL_OUT, m_alu);
        chk("dst_out", 64'(REG_DESTINATION_OUT), 64'(m_dst));
        chk("regwrite_out", 64'(REGWRITE_OUT), 64'(m_rw));
        chk("mem2reg_out", 64'(MEM2REG_OUT), 64'(m_m2r));
        if (m_pending) begin
            chk("we", 64'(DMEM_WE), 64'(m_is_write));
            chk("addr", DMEM_ADDR, m_addr);
            chk("wdata", DMEM_WDATA, m_wdata);
        end
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_ctl();
        MEMREAD_IN = 0; MEMWRITE_IN = 0; REGWRITE_IN = 0;
        MEM2REG_IN = 0; DMEM_ACK = 0;
    endtask

    initial begin
        int stalls;
        step(); step();
        RESET = 0;
        chk("rst_req", 64'(DMEM_REQ), 64'd0);
        chk("rst_rd", READ_DATA_OUT, 64'd0);
        chk("rst_addr", DMEM_ADDR, 64'd0);

        // plain ALU op
        ALU_VAL_IN = 64'h1234; REGWRITE_IN = 1; REG_DESTINATION_IN = 5;
        chk("alu_nostall", 64'(STALL), 64'd0);
        step();
        chk("alu_val", ALU_VAL_OUT, 64'h1234);
        chk("alu_dst", 64'(REG_DESTINATION_OUT), 64'd5);
        chk("alu_rw", 64'(REGWRITE_OUT), 64'd1);

        // load, ACK arrives on the fourth WAIT cycle
        ALU_VAL_IN = 64'h40; MEMREAD_IN = 1; MEM2REG_IN = 1;
        REG_DESTINATION_IN = 7;
        stalls = 0;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                DMEM_ACK = 1; DMEM_RDATA = 64'hDEADBEEF;
            end
            #1;
            if (STALL) stalls++;
            step();
            if (k == 0) begin
                chk("ld_addr", DMEM_ADDR, 64'h40);
                chk("ld_we", 64'(DMEM_WE), 64'd0);
                chk("ld_bubble", 64'(REGWRITE_OUT), 64'd0);
            end
        end
        chk("ld_stalls", 64'(stalls), 64'd4);
        chk("ld_data", READ_DATA_OUT, 64'hDEADBEEF);
        chk("ld_m2r", 64'(MEM2REG_OUT), 64'd1);
        chk("ld_req_drop", 64'(DMEM_REQ), 64'd0);
        clear_ctl();

        // store with both read and write set, immediate ACK
        ALU_VAL_IN = 64'h80; RT_READ_IN = 64'h55;
        MEMREAD_IN = 1; MEMWRITE_IN = 1;
        step();
        chk("st_we", 64'(DMEM_WE), 64'd1);
        chk("st_wdata", DMEM_WDATA, 64'h55);
        DMEM_ACK = 1; DMEM_RDATA = 64'h777;
        step();
        clear_ctl();
        chk("st_rd_hold", READ_DATA_OUT, 64'hDEADBEEF);
        chk("st_req_drop", 64'(DMEM_REQ), 64'd0);

        // stray ACK in IDLE
        DMEM_ACK = 1; DMEM_RDATA = 64'h999;
        step();
        DMEM_ACK = 0;
        chk("stray_ack", READ_DATA_OUT, 64'hDEADBEEF);

        // branch resolution
        BRANCH_ZERO_IN = 1; ZERO_IN = 1; BRANCH_IN = 64'h100;
        #1;
        chk("br_taken", 64'(PCSRC), 64'd1);
        chk("br_target", BRANCH_TARGET, 64'h100);
        ZERO_IN = 0;
        #1;
        chk("br_not_taken", 64'(PCSRC), 64'd0);
        step();
        BRANCH_ZERO_IN = 0;

        // timeout: no ACK for MW WAIT cycles
        ALU_VAL_IN = 64'h200; MEMREAD_IN = 1;
        step();
        for (int k = 0; k < MW - 1; k++) step();
        chk("to_req_still", 64'(DMEM_REQ), 64'd1);
        chk("to_err_not_yet", 64'(MEM_ERROR), 64'd0);
        step();
        chk("to_req_drop", 64'(DMEM_REQ), 64'd0);
        chk("to_err", 64'(MEM_ERROR), 64'd1);
        clear_ctl();
        DMEM_ACK = 1;
        step(); step();
        DMEM_ACK = 0;
        chk("to_stuck", 64'(STALL), 64'd1);

        // reset out of error, then reset in the middle of an access
        RESET = 1; step(); RESET = 0;
        chk("err_cleared", 64'(MEM_ERROR), 64'd0);
        ALU_VAL_IN = 64'h300; MEMREAD_IN = 1; REGWRITE_IN = 1;
        step();
        chk("mid_req", 64'(DMEM_REQ), 64'd1);
        RESET = 1;
        #1;
        chk("mid_rst_req", 64'(DMEM_REQ), 64'd0);
        chk("mid_rst_err", 64'(MEM_ERROR), 64'd0);
        chk("mid_rst_alu", ALU_VAL_OUT, 64'd0);
        chk("mid_rst_rd", READ_DATA_OUT, 64'd0);
        DMEM_ACK = 1; DMEM_RDATA = 64'hBAD;
        step();
        clear_ctl();
        RESET = 0;
        DMEM_ACK = 1;
        step();
        DMEM_ACK = 0;
        chk("late_ack", READ_DATA_OUT, 64'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
